sram_sched: RTL

//  Frame-level sequencer for sram_system: drives wen/cs_wr/addr_wr during a write phase and cs_rd/addr_rd

---
 rtl/sram_sched_if.sv | 33 +++
 rtl/sram_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sram_sched_if.sv
// Control bundle between the frame sequencer and its neighbours: upstream
// write handshake, downstream read handshake, and the SRAM control lines.
interface sram_sched_if #(
  parameter int AddrLWidth = 7
);
  logic                  start_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  out_ready_i;
  logic [3:0]            wen_o;
  logic [1:0]            cs_wr_o;
  logic [AddrLWidth-1:0] addr_wr_o;
  logic [2:0]            cs_rd_o;
  logic [AddrLWidth-1:0] addr_rd_o;
  logic                  out_valid_o;
  logic                  out_last_o;
  logic                  busy_o;
  logic                  done_o;

  // Sequencer side
  modport master (
    input  start_i, in_valid_i, out_ready_i,
    output in_ready_o, wen_o, cs_wr_o, addr_wr_o, cs_rd_o, addr_rd_o,
           out_valid_o, out_last_o, busy_o, done_o
  );

  // Environment side (upstream source, downstream sink, SRAM)
  modport slave (
    output start_i, in_valid_i, out_ready_i,
    input  in_ready_o, wen_o, cs_wr_o, addr_wr_o, cs_rd_o, addr_rd_o,
           out_valid_o, out_last_o, busy_o, done_o
  );
endinterface

// File: rtl/sram_sched.sv
// Frame sequencer for sram_system. A frame is written row-wise (long bank
// first, then the three short banks) and read back column-wise, one column
// beat per cycle. Only control is generated here; data flows around us.
module sram_sched #(
  parameter int AddrLWidth = 7,
  parameter int AddrSWidth = 5,
  parameter int RdLatency  = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sram_sched_if.master  bus
);
  localparam int LDepth = 1 << AddrLWidth;
  localparam int SDepth = 1 << AddrSWidth;
  localparam int NBeats = LDepth + 3 * SDepth;
  localparam int CntW   = $clog2(NBeats);

  localparam logic [CntW-1:0] LongRows   = CntW'(LDepth);
  localparam logic [CntW-1:0] LastWrBeat = CntW'(NBeats - 1);
  localparam logic [CntW-1:0] LastRdBeat = CntW'(LDepth - 1);
  localparam logic [CntW-1:0] LastDrain  = CntW'(RdLatency - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            cs_wr_q, cs_wr_d;
  logic [AddrLWidth-1:0] addr_wr_q, addr_wr_d;
  logic [2:0]            cs_rd_q, cs_rd_d;
  logic [AddrLWidth-1:0] addr_rd_q, addr_rd_d;
  logic [RdLatency-1:0]  vld_sr_q, last_sr_q;

  logic                  accept;
  logic                  issue;
  logic [3:0]            wen;
  logic                  done;
  logic [CntW-1:0]       short_off;

  assign accept    = (state_q == WRITE) && bus.in_valid_i;
  assign issue     = (state_q == READ) && bus.out_ready_i;
  // Row index within the concatenated short banks (valid once cnt >= LDepth)
  assign short_off = cnt_q - LongRows;

  // Next-state, counter and bank/address selection; idle cycles hold the last address
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cs_wr_d   = cs_wr_q;
    addr_wr_d = addr_wr_q;
    cs_rd_d   = cs_rd_q;
    addr_rd_d = addr_rd_q;
    wen       = 4'b0000;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (accept) begin
          if (cnt_q < LongRows) begin
            wen       = 4'b0001;
            cs_wr_d   = 2'd0;
            addr_wr_d = cnt_q[AddrLWidth-1:0];
          end else begin
            wen       = 4'b0010 << (short_off >> AddrSWidth);
            cs_wr_d   = 2'(short_off >> AddrSWidth) + 2'd1;
            addr_wr_d = AddrLWidth'(short_off[AddrSWidth-1:0]);
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastWrBeat) begin
            state_d = READ;
            cnt_d   = '0;
          end
        end
      end
      READ: begin
        if (issue) begin
          // Column mode: bit 2 selects transposed read, low bits pick the long-bank column
          cs_rd_d   = 3'b100 + 3'(cnt_q[AddrLWidth-1:AddrSWidth]);
          addr_rd_d = AddrLWidth'(cnt_q[AddrSWidth-1:0]);
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LastRdBeat) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastDrain) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and held SRAM address registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cs_wr_q   <= '0;
      addr_wr_q <= '0;
      cs_rd_q   <= '0;
      addr_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cs_wr_q   <= cs_wr_d;
      addr_wr_q <= addr_wr_d;
      cs_rd_q   <= cs_rd_d;
      addr_rd_q <= addr_rd_d;
    end
  end

  // Delay line matching the SRAM read latency for valid/last qualifiers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_sr_q  <= '0;
      last_sr_q <= '0;
    end else begin
      vld_sr_q[0]  <= issue;
      last_sr_q[0] <= issue && (cnt_q == LastRdBeat);
      for (int i = 1; i < RdLatency; i++) begin
        vld_sr_q[i]  <= vld_sr_q[i-1];
        last_sr_q[i] <= last_sr_q[i-1];
      end
    end
  end

  assign bus.in_ready_o  = (state_q == WRITE);
  assign bus.wen_o       = wen;
  assign bus.cs_wr_o     = cs_wr_d;
  assign bus.addr_wr_o   = addr_wr_d;
  assign bus.cs_rd_o     = cs_rd_d;
  assign bus.addr_rd_o   = addr_rd_d;
  assign bus.out_valid_o = vld_sr_q[RdLatency-1];
  assign bus.out_last_o  = last_sr_q[RdLatency-1];
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = done;
endmodule
